// File: rtl/fpmac_dot_seq.sv
// fpmac_dot_seq: sequences a stream of FP16 (in, weight) pairs into an external
// fpmac unit one element at a time. Each fpmac result is fed back as the next
// accumulator operand. The block returns bias + sum(in_i * weight_i) and a
// sticky overflow flag. All values pass through bit-exact.
module fpmac_dot_seq #(
    parameter int MAC_LAT = 2,
    parameter int LEN_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      bias,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic [15:0]      w_data,
    output logic             in_ready,
    output logic [15:0]      mac_in,
    output logic [15:0]      mac_weight,
    output logic [15:0]      mac_acc,
    input  logic [15:0]      mac_out,
    input  logic             mac_overflow,
    output logic             res_valid,
    output logic [15:0]      res_data,
    output logic             res_overflow,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The wait counter only has to reach MAC_LAT-1; keep at least one bit.
    localparam int             WC_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAC_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      acc_reg;
    logic [LEN_W-1:0] cnt;
    logic             ovf;
    logic [WC_W-1:0]  wcnt;
    logic             wait_done;

    // fpmac result is sampled on the edge that ends its MAC_LAT-th cycle.
    assign wait_done = (wcnt == WC_LAST);

    // State register; reset drops any operation in progress back to IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one element in flight at a time because of the acc dependency.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (in_valid) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    state_nxt = (cnt == LEN_W'(1)) ? DONE : ISSUE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: accumulator, element counter, sticky overflow and fpmac operand registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_reg    <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            wcnt       <= '0;
            mac_in     <= '0;
            mac_weight <= '0;
            mac_acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= len;
                        acc_reg <= bias;
                        ovf     <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (in_valid) begin
                        mac_in     <= in_data;
                        mac_weight <= w_data;
                        mac_acc    <= acc_reg;
                        wcnt       <= '0;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        acc_reg <= mac_out;
                        ovf     <= ovf | mac_overflow;
                        cnt     <= cnt - LEN_W'(1);
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state only; result fields are zero outside DONE.
    always_comb begin
        in_ready     = (state == ISSUE);
        busy         = (state != IDLE);
        res_valid    = (state == DONE);
        res_data     = (state == DONE) ? acc_reg : 16'h0000;
        res_overflow = (state == DONE) ? ovf : 1'b0;
    end

endmodule

// File: tb/tb_fpmac_dot_seq.sv
// Bench for fpmac_dot_seq: a small table-driven fpmac stand-in with MAC_LAT
// latency, directed runs with hand-computed FP16 results, and a scoreboard
// monitor that pops expected results whenever a result is accepted.
module tb_fpmac_dot_seq;

    localparam int MAC_LAT = 2;
    localparam int LEN_W   = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [15:0]      bias = '0;
    logic             in_valid = 1'b0;
    logic [15:0]      in_data = '0;
    logic [15:0]      w_data = '0;
    logic             in_ready;
    logic [15:0]      mac_in;
    logic [15:0]      mac_weight;
    logic [15:0]      mac_acc;
    logic [15:0]      mac_out;
    logic             mac_overflow;
    logic             res_valid;
    logic [15:0]      res_data;
    logic             res_overflow;
    logic             res_ready = 1'b1;
    logic             busy;

    int n_total = 0;
    int n_pass  = 0;

    logic [16:0] exp_q[$];
    logic [16:0] fp_q = '0;

    fpmac_dot_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .w_data(w_data), .in_ready(in_ready),
        .mac_in(mac_in), .mac_weight(mac_weight), .mac_acc(mac_acc),
        .mac_out(mac_out), .mac_overflow(mac_overflow),
        .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Hand-computed fpmac results {overflow, in*weight+acc}; unknown triples give NaN.
    function automatic logic [16:0] fp_model(input logic [15:0] a, input logic [15:0] w,
                                             input logic [15:0] c);
        case ({a, w, c})
            {16'h3C00, 16'h4000, 16'h3C00}: return {1'b0, 16'h4200}; // 1*2+1 = 3
            {16'h4000, 16'h4000, 16'h4200}: return {1'b0, 16'h4700}; // 2*2+3 = 7
            {16'h7BFF, 16'h7BFF, 16'h0000}: return {1'b1, 16'h7C00}; // overflow -> inf
            {16'h3C00, 16'h3C00, 16'h0000}: return {1'b0, 16'h3C00}; // 1*1+0 = 1
            {16'h4000, 16'h3C00, 16'h3C00}: return {1'b0, 16'h4200}; // 2*1+1 = 3
            {16'h3C00, 16'h3C00, 16'h3C00}: return {1'b0, 16'h4000}; // 1*1+1 = 2
            {16'h4000, 16'h4200, 16'h0000}: return {1'b0, 16'h4600}; // 2*3+0 = 6
            {16'h3C00, 16'h3C00, 16'h7C00}: return {1'b0, 16'h7C00}; // 1+inf = inf
            default:                        return {1'b0, 16'h7E00};
        endcase
    endfunction

    // fpmac stand-in: result appears MAC_LAT-1 edges after operands change.
    always @(posedge CLK) fp_q <= fp_model(mac_in, mac_weight, mac_acc);
    assign mac_out      = fp_q[15:0];
    assign mac_overflow = fp_q[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: every accepted result must match the oldest expectation.
    always @(negedge CLK) begin
        if (RST && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got %h/%0b expected none", res_data, res_overflow);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("res_data", 32'(res_data), 32'(e[15:0]));
                check("res_overflow", 32'(res_overflow), 32'(e[16]));
            end
        end
    end

    task automatic do_start(input logic [LEN_W-1:0] l, input logic [15:0] b);
        start = 1'b1;
        len   = l;
        bias  = b;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] a, input logic [15:0] w, input logic [15:0] exp_acc);
        int n = 0;
        in_valid = 1'b1;
        in_data  = a;
        w_data   = w;
        while (!in_ready && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check("mac_in", 32'(mac_in), 32'(a));
        check("mac_weight", 32'(mac_weight), 32'(w));
        check("mac_acc", 32'(mac_acc), 32'(exp_acc));
        check("in_ready_wait_state", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_res_valid();
        int n = 0;
        while (!res_valid && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("rst_outputs", {in_ready, busy, res_valid, res_overflow, res_data},
              32'd0);
        check("rst_mac", {mac_in, mac_weight}, 32'd0);
        check("rst_mac_acc", 32'(mac_acc), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;

        // T1: 1 + 1*2 + 2*2 = 7.0
        exp_q.push_back({1'b0, 16'h4700});
        do_start(8'd2, 16'h3C00);
        check("t1_busy", 32'(busy), 32'd1);
        feed(16'h3C00, 16'h4000, 16'h3C00);
        feed(16'h4000, 16'h4000, 16'h4200);
        wait_idle();

        // T2: zero-length run returns bias next cycle, never asserts in_ready
        exp_q.push_back({1'b0, 16'h4200});
        check("t2_idle_in_ready", 32'(in_ready), 32'd0);
        do_start(8'd0, 16'h4200);
        check("t2_res_valid", 32'(res_valid), 32'd1);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        check("t2_res_data", 32'(res_data), 32'h4200);
        @(posedge CLK); #1;
        check("t2_busy_after", 32'(busy), 32'd0);

        // T3: overflow flagged, then cleared on the next start
        exp_q.push_back({1'b1, 16'h7C00});
        do_start(8'd1, 16'h0000);
        feed(16'h7BFF, 16'h7BFF, 16'h0000);
        wait_idle();
        exp_q.push_back({1'b0, 16'h3C00});
        do_start(8'd1, 16'h0000);
        feed(16'h3C00, 16'h3C00, 16'h0000);
        wait_idle();

        // T3b: overflow is sticky across later non-overflowing elements
        exp_q.push_back({1'b1, 16'h7C00});
        do_start(8'd2, 16'h0000);
        feed(16'h7BFF, 16'h7BFF, 16'h0000);
        feed(16'h3C00, 16'h3C00, 16'h7C00);
        wait_idle();

        // T4: stalls of 5 cycles between pairs; in_ready stays up in ISSUE
        exp_q.push_back({1'b0, 16'h4700});
        do_start(8'd3, 16'h0000);
        feed(16'h3C00, 16'h3C00, 16'h0000);
        repeat (MAC_LAT) @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_in_ready", 32'(in_ready), 32'd1);
            @(posedge CLK); #1;
        end
        feed(16'h4000, 16'h3C00, 16'h3C00);
        repeat (MAC_LAT + 5) @(posedge CLK);
        #1;
        check("t4_stall2_in_ready", 32'(in_ready), 32'd1);
        feed(16'h4000, 16'h4000, 16'h4200);
        wait_idle();

        // T5: result held while res_ready low; start in DONE ignored
        res_ready = 1'b0;
        exp_q.push_back({1'b0, 16'h4000});
        do_start(8'd1, 16'h3C00);
        feed(16'h3C00, 16'h3C00, 16'h3C00);
        wait_res_valid();
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_valid", 32'(res_valid), 32'd1);
            check("t5_hold_data", 32'(res_data), 32'h4000);
            if (i == 1) begin
                start = 1'b1;
                len   = 8'd0;
                bias  = 16'h1234;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(posedge CLK); #1;
        check("t5_busy_after", 32'(busy), 32'd0);
        check("t5_valid_after", 32'(res_valid), 32'd0);
        @(posedge CLK); #1;
        check("t5_still_idle", 32'(busy), 32'd0);

        // T6: reset during WAIT of element 2 of 4, then a clean single-element run
        do_start(8'd4, 16'h0000);
        feed(16'h3C00, 16'h3C00, 16'h0000);
        feed(16'h4000, 16'h3C00, 16'h3C00);
        #2;
        RST = 1'b0;
        #1;
        check("t6_rst_outputs", {in_ready, busy, res_valid, res_overflow, res_data},
              32'd0);
        check("t6_rst_mac", {mac_in, mac_weight}, 32'd0);
        check("t6_rst_mac_acc", 32'(mac_acc), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("t6_idle_after_rst", 32'(busy), 32'd0);
        exp_q.push_back({1'b0, 16'h4600});
        do_start(8'd1, 16'h0000);
        feed(16'h4000, 16'h4200, 16'h0000);
        wait_idle();

        repeat (3) @(posedge CLK);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
